// File: rtl/blob_bbox_stats.sv
// Per-label bounding box and pixel-count accumulator fed by the connected-components label stream.
// Define BLOB_BBOX_CENTROID_EN to also keep per-label coordinate sums for centroid computation.
module blob_bbox_stats #(
    parameter int LABEL_WIDTH = 8,
    parameter int MAX_LABELS  = 16,
    parameter int COORD_WIDTH = 11,
    parameter int COUNT_WIDTH = 20
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               en,
    input  logic                               hsync,
    input  logic                               vsync,
    input  logic [LABEL_WIDTH-1:0]             label,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [LABEL_WIDTH-1:0]             out_label,
    output logic [COORD_WIDTH-1:0]             out_xmin,
    output logic [COORD_WIDTH-1:0]             out_xmax,
    output logic [COORD_WIDTH-1:0]             out_ymin,
    output logic [COORD_WIDTH-1:0]             out_ymax,
    output logic [COUNT_WIDTH-1:0]             out_count,
    output logic [COORD_WIDTH+COUNT_WIDTH-1:0] out_sum_x,
    output logic [COORD_WIDTH+COUNT_WIDTH-1:0] out_sum_y,
    output logic                               frame_done,
    output logic                               busy,
    output logic                               label_overflow,
    output logic                               pixel_dropped
);
    localparam int IDX_W = $clog2(MAX_LABELS);
    localparam int SUM_W = COORD_WIDTH + COUNT_WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_LABELS - 1);
    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [0:0]             state;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       lbl_idx;
    logic [COORD_WIDTH-1:0] x;
    logic [COORD_WIDTH-1:0] y;

    logic [COORD_WIDTH-1:0] tab_xmin  [MAX_LABELS];
    logic [COORD_WIDTH-1:0] tab_xmax  [MAX_LABELS];
    logic [COORD_WIDTH-1:0] tab_ymin  [MAX_LABELS];
    logic [COORD_WIDTH-1:0] tab_ymax  [MAX_LABELS];
    logic [COUNT_WIDTH-1:0] tab_count [MAX_LABELS];
`ifdef BLOB_BBOX_CENTROID_EN
    logic [SUM_W-1:0]       tab_sum_x [MAX_LABELS];
    logic [SUM_W-1:0]       tab_sum_y [MAX_LABELS];
`else
    assign out_sum_x = '0;
    assign out_sum_y = '0;
`endif

    logic label_in_range;
    logic accumulate;
    logic drain_advance;

    assign label_in_range = (32'(label) < 32'(MAX_LABELS));
    assign lbl_idx        = label[IDX_W-1:0];
    assign accumulate     = en && !hsync && !vsync && (state == ST_ACCUM)
                            && (label != '0) && label_in_range;
    // Move to the next entry once the current one is empty or has been handed off.
    assign drain_advance  = (state == ST_DRAIN)
                            && ((out_valid && out_ready) || (!out_valid && tab_count[idx] == '0));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < MAX_LABELS; i++) begin
                tab_xmin[i]  <= '1;
                tab_ymin[i]  <= '1;
                tab_xmax[i]  <= '0;
                tab_ymax[i]  <= '0;
                tab_count[i] <= '0;
`ifdef BLOB_BBOX_CENTROID_EN
                tab_sum_x[i] <= '0;
                tab_sum_y[i] <= '0;
`endif
            end
            state          <= ST_ACCUM;
            idx            <= '0;
            x              <= '0;
            y              <= '0;
            out_valid      <= 1'b0;
            out_label      <= '0;
            out_xmin       <= '0;
            out_xmax       <= '0;
            out_ymin       <= '0;
            out_ymax       <= '0;
            out_count      <= '0;
`ifdef BLOB_BBOX_CENTROID_EN
            out_sum_x      <= '0;
            out_sum_y      <= '0;
`endif
            frame_done     <= 1'b0;
            busy           <= 1'b0;
            label_overflow <= 1'b0;
            pixel_dropped  <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if (vsync) begin
                x <= '0;
                y <= '0;
            end else if (hsync) begin
                x <= '0;
                if (y != '1) y <= y + 1'b1;
            end else if (en && x != '1) begin
                x <= x + 1'b1;
            end

            if (en && state == ST_ACCUM && !label_in_range) label_overflow <= 1'b1;
            if (en && state == ST_DRAIN) pixel_dropped <= 1'b1;

            // Table reads here see last cycle's writes, so back-to-back hits on one label are safe.
            if (accumulate) begin
                if (x < tab_xmin[lbl_idx]) tab_xmin[lbl_idx] <= x;
                if (x > tab_xmax[lbl_idx]) tab_xmax[lbl_idx] <= x;
                if (y < tab_ymin[lbl_idx]) tab_ymin[lbl_idx] <= y;
                if (y > tab_ymax[lbl_idx]) tab_ymax[lbl_idx] <= y;
                if (tab_count[lbl_idx] != '1) tab_count[lbl_idx] <= tab_count[lbl_idx] + 1'b1;
`ifdef BLOB_BBOX_CENTROID_EN
                tab_sum_x[lbl_idx] <= tab_sum_x[lbl_idx] + SUM_W'(x);
                tab_sum_y[lbl_idx] <= tab_sum_y[lbl_idx] + SUM_W'(y);
`endif
            end

            case (state)
                ST_ACCUM: begin
                    if (vsync) begin
                        state <= ST_DRAIN;
                        idx   <= IDX_W'(1);
                        busy  <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (out_valid) begin
                        if (out_ready) begin
                            out_valid      <= 1'b0;
                            tab_xmin[idx]  <= '1;
                            tab_ymin[idx]  <= '1;
                            tab_xmax[idx]  <= '0;
                            tab_ymax[idx]  <= '0;
                            tab_count[idx] <= '0;
`ifdef BLOB_BBOX_CENTROID_EN
                            tab_sum_x[idx] <= '0;
                            tab_sum_y[idx] <= '0;
`endif
                        end
                    end else if (tab_count[idx] != '0) begin
                        out_valid <= 1'b1;
                        out_label <= LABEL_WIDTH'(idx);
                        out_xmin  <= tab_xmin[idx];
                        out_xmax  <= tab_xmax[idx];
                        out_ymin  <= tab_ymin[idx];
                        out_ymax  <= tab_ymax[idx];
                        out_count <= tab_count[idx];
`ifdef BLOB_BBOX_CENTROID_EN
                        out_sum_x <= tab_sum_x[idx];
                        out_sum_y <= tab_sum_y[idx];
`endif
                    end

                    if (drain_advance) begin
                        if (idx == LAST_IDX) begin
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            state      <= ST_ACCUM;
                            idx        <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= ST_ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_blob_bbox_stats.sv
// Scoreboard bench for blob_bbox_stats: a behavioural label table predicts each drained record,
// and a negedge monitor compares every presented record against the queue head.
`timescale 1ns/1ps
module tb_blob_bbox_stats;
    localparam int MAXL = 16;

    typedef struct {
        int     lbl;
        int     xmin;
        int     xmax;
        int     ymin;
        int     ymax;
        int     count;
        longint sx;
        longint sy;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en, hsync, vsync, out_ready;
    logic [7:0]  label;
    logic        out_valid, frame_done, busy, label_overflow, pixel_dropped;
    logic [7:0]  out_label;
    logic [10:0] out_xmin, out_xmax, out_ymin, out_ymax;
    logic [19:0] out_count;
    logic [30:0] out_sum_x, out_sum_y;

    int     checks = 0;
    int     errors = 0;
    rec_t   exp_q[$];
    int     m_count[MAXL], m_xmin[MAXL], m_xmax[MAXL], m_ymin[MAXL], m_ymax[MAXL];
    longint m_sx[MAXL], m_sy[MAXL];
    int     mx, my;
    bit     in_drain;
    bit     rand_ready;
    bit     was_held;
    int     ncyc;

    blob_bbox_stats dut (
        .clk(clk), .reset_n(reset_n), .en(en), .hsync(hsync), .vsync(vsync), .label(label),
        .out_valid(out_valid), .out_ready(out_ready), .out_label(out_label),
        .out_xmin(out_xmin), .out_xmax(out_xmax), .out_ymin(out_ymin), .out_ymax(out_ymax),
        .out_count(out_count), .out_sum_x(out_sum_x), .out_sum_y(out_sum_y),
        .frame_done(frame_done), .busy(busy), .label_overflow(label_overflow),
        .pixel_dropped(pixel_dropped)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < MAXL; i++) begin
            m_count[i] = 0; m_xmin[i] = 2047; m_xmax[i] = 0;
            m_ymin[i] = 2047; m_ymax[i] = 0; m_sx[i] = 0; m_sy[i] = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pixelRun(input int lbl, input int n);
        for (int k = 0; k < n; k++) begin
            en = 1'b1;
            label = 8'(lbl);
            step();
            if (!in_drain && lbl > 0 && lbl < MAXL) begin
                m_count[lbl]++;
                if (mx < m_xmin[lbl]) m_xmin[lbl] = mx;
                if (mx > m_xmax[lbl]) m_xmax[lbl] = mx;
                if (my < m_ymin[lbl]) m_ymin[lbl] = my;
                if (my > m_ymax[lbl]) m_ymax[lbl] = my;
                m_sx[lbl] += mx;
                m_sy[lbl] += my;
            end
            if (mx < 2047) mx++;
        end
        en = 1'b0;
        label = 8'd0;
    endtask

    task automatic newRow();
        hsync = 1'b1;
        step();
        hsync = 1'b0;
        mx = 0;
        if (my < 2047) my++;
    endtask

    // Closing vsync: every non-empty model entry becomes an expected record, in label order.
    task automatic endFrame();
        rec_t r;
        vsync = 1'b1;
        step();
        vsync = 1'b0;
        mx = 0;
        my = 0;
        for (int i = 1; i < MAXL; i++) begin
            if (m_count[i] > 0) begin
                r.lbl = i; r.xmin = m_xmin[i]; r.xmax = m_xmax[i];
                r.ymin = m_ymin[i]; r.ymax = m_ymax[i]; r.count = m_count[i];
`ifdef BLOB_BBOX_CENTROID_EN
                r.sx = m_sx[i] % (64'd1 << 31);
                r.sy = m_sy[i] % (64'd1 << 31);
`else
                r.sx = 0;
                r.sy = 0;
`endif
                exp_q.push_back(r);
            end
        end
        clearModel();
        in_drain = 1'b1;
    endtask

    task automatic waitFrameDone(input int budget, output int cycles);
        cycles = 0;
        while (!frame_done && cycles < budget) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            step();
            cycles++;
        end
        if (!frame_done) checkOutput("frame_done_timeout", 0, 1);
        checkOutput("queue_drained", exp_q.size(), 0);
        in_drain = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic waitValid(input int budget);
        int n = 0;
        while (!out_valid && n < budget) begin
            step();
            n++;
        end
        checkOutput("valid_seen", out_valid, 1);
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            was_held <= 1'b0;
        end else begin
            if (was_held && !out_valid) checkOutput("valid_withdrawn", 0, 1);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_record", out_label, 0);
                end else begin
                    checkOutput("rec_label", out_label, exp_q[0].lbl);
                    checkOutput("rec_xmin", out_xmin, exp_q[0].xmin);
                    checkOutput("rec_xmax", out_xmax, exp_q[0].xmax);
                    checkOutput("rec_ymin", out_ymin, exp_q[0].ymin);
                    checkOutput("rec_ymax", out_ymax, exp_q[0].ymax);
                    checkOutput("rec_count", out_count, exp_q[0].count);
                    checkOutput("rec_sum_x", out_sum_x, exp_q[0].sx);
                    checkOutput("rec_sum_y", out_sum_y, exp_q[0].sy);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            was_held <= out_valid && !out_ready;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: got 0, expected 1");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic applyStimulus();
        reset_n = 1'b0; en = 1'b0; hsync = 1'b0; vsync = 1'b0; label = 8'd0; out_ready = 1'b1;
        rand_ready = 1'b0; in_drain = 1'b0; mx = 0; my = 0;
        clearModel();
        step(); step();
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_frame_done", frame_done, 0);
        checkOutput("rst_overflow", label_overflow, 0);
        checkOutput("rst_dropped", pixel_dropped, 0);
        checkOutput("rst_out_label", out_label, 0);
        checkOutput("rst_out_xmin", out_xmin, 0);
        checkOutput("rst_out_count", out_count, 0);
        reset_n = 1'b1;

        // Single blob of label 3 at (2,1), (5,1), (4,4)
        newRow();
        pixelRun(0, 2); pixelRun(3, 1); pixelRun(0, 2); pixelRun(3, 1);
        newRow(); newRow(); newRow();
        pixelRun(0, 4); pixelRun(3, 1);
        endFrame();
        checkOutput("blob_record_count", exp_q.size(), 1);
        waitFrameDone(100, ncyc);

        // Labels 1 and 7, consumer stalls the first record for 5 cycles
        pixelRun(1, 3); pixelRun(0, 2); pixelRun(7, 2);
        newRow();
        pixelRun(7, 1); pixelRun(1, 1);
        out_ready = 1'b0;
        endFrame();
        waitValid(20);
        for (int k = 0; k < 5; k++) begin
            checkOutput("hold_valid", out_valid, 1);
            checkOutput("hold_label", out_label, 1);
            step();
        end
        out_ready = 1'b1;
        waitFrameDone(100, ncyc);

        // Empty frame
        endFrame();
        checkOutput("empty_busy", busy, 1);
        waitFrameDone(100, ncyc);
        checkOutput("empty_latency", ncyc, 15);
        checkOutput("empty_busy_done", busy, 0);

        // Out-of-range and background labels only
        pixelRun(20, 2); pixelRun(0, 3);
        endFrame();
        waitFrameDone(100, ncyc);
        checkOutput("overflow_set", label_overflow, 1);

        // Pixels arriving during drain are dropped
        pixelRun(5, 3);
        endFrame();
        pixelRun(5, 4);
        waitFrameDone(100, ncyc);
        checkOutput("dropped_set", pixel_dropped, 1);
        newRow();
        pixelRun(0, 1); pixelRun(6, 2);
        endFrame();
        waitFrameDone(100, ncyc);
        checkOutput("overflow_sticky", label_overflow, 1);

        // Random sparse frames with a randomly stalling consumer
        for (int f = 0; f < 3; f++) begin
            for (int r = 0; r < 5; r++) begin
                newRow();
                for (int p = 0; p < 14; p++)
                    pixelRun(($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 15)) : 0, 1);
            end
            rand_ready = 1'b1;
            endFrame();
            waitFrameDone(400, ncyc);
            rand_ready = 1'b0;
        end

        // Reset in the middle of a stalled drain
        pixelRun(2, 2); pixelRun(9, 1);
        out_ready = 1'b0;
        endFrame();
        waitValid(20);
        reset_n = 1'b0;
        step();
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_out_label", out_label, 0);
        checkOutput("midrst_overflow", label_overflow, 0);
        checkOutput("midrst_dropped", pixel_dropped, 0);
        reset_n = 1'b1;
        exp_q.delete();
        clearModel();
        mx = 0; my = 0; in_drain = 1'b0;
        out_ready = 1'b1;
        endFrame();
        waitFrameDone(100, ncyc);
        checkOutput("post_rst_latency", ncyc, 15);
    endtask

    initial begin
        applyStimulus();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
